// File: rtl/qea_host_sequencer.sv
// Host-side initiator for the QEA core: loads gate contexts, clears the state RAM to |0...0>,
// starts the core, times execution and streams the final state vector back out.
module qea_host_sequencer #(
  parameter int unsigned PE_NUM                  = 4,
  parameter int unsigned STATE_DATA_WIDTH        = 64,
  parameter int unsigned STATE_ADDR_WIDTH        = 16,
  parameter int unsigned GATE_CONTEXT_DATA_WIDTH = 64,
  parameter int unsigned GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int unsigned MAX_QBIT_WIDTH          = 6,
  parameter int unsigned RD_LAT                  = 1,
  parameter logic [STATE_DATA_WIDTH-1:0] INIT_AMP = 64'h4000_0000_0000_0000
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_go,
  input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
  input  logic [GATE_CONTEXT_ADDR_WIDTH:0]     i_ins_num,
  input  logic                                 i_ctx_valid,
  output logic                                 o_ctx_ready,
  input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_data,
  output logic                                 o_qea_start,
  output logic [MAX_QBIT_WIDTH-1:0]            o_qea_qbit_num,
  output logic                                 o_qea_ctx_en,
  output logic                                 o_qea_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_qea_ctx_addr,
  output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_qea_ctx_data,
  output logic                                 o_qea_state_ena,
  output logic                                 o_qea_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]          o_qea_state_addr,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_qea_state_din,
  input  logic                                 i_qea_complete,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_qea_state_dout,
  output logic                                 o_res_valid,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_res_data,
  output logic                                 o_res_last,
  input  logic                                 i_res_ready,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_err,
  output logic [31:0]                          o_exec_cycles
);

  localparam int unsigned SW = PE_NUM * STATE_DATA_WIDTH;
  localparam int unsigned CW = STATE_ADDR_WIDTH + 1;         // word count incl. full range
  localparam int unsigned NW = GATE_CONTEXT_ADDR_WIDTH + 1;
  localparam logic [MAX_QBIT_WIDTH-1:0] QMin = MAX_QBIT_WIDTH'(2);
  localparam logic [MAX_QBIT_WIDTH-1:0] QMax = MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH + 2);
  // INIT_AMP sits in the most significant PE slot
  localparam logic [SW-1:0] InitWord = SW'(INIT_AMP) << (SW - STATE_DATA_WIDTH);

  typedef enum logic [2:0] {StIdle, StLdCtx, StLdSt, StStart, StWait, StRead} state_e;

  state_e                             state_q, state_d;
  logic [MAX_QBIT_WIDTH-1:0]          qbit_q, qbit_d;
  logic [NW-1:0]                      ins_q, ins_d, ctx_cnt_q, ctx_cnt_d;
  logic [CW-1:0]                      nwords_q, nwords_d, cnt_q, cnt_d, res_cnt_q, res_cnt_d;
  logic [31:0]                        exec_q, exec_d;
  logic                               err_q, err_d, done_q, done_d, ctx_en_q, ctx_en_d;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ctx_addr_q, ctx_addr_d;
  logic [GATE_CONTEXT_DATA_WIDTH-1:0] ctx_data_q, ctx_data_d;
  logic [RD_LAT-1:0]                  pipe_q, pipe_d;
  logic [2:0]                         occ_q, occ_d, inflight;
  logic [1:0]                         wr_ptr_q, rd_ptr_q;
  logic [SW-1:0]                      fifo_q [4];
  logic                               q_bad, issue, push, pop, last_word;

  assign q_bad     = (i_qbit_num < QMin) || (i_qbit_num > QMax);
  assign push      = pipe_q[RD_LAT-1];
  assign pop       = (occ_q != 3'd0) && i_res_ready;
  assign last_word = (res_cnt_q == nwords_q - CW'(1));
  assign occ_d     = occ_q + 3'(push) - 3'(pop);

  assign o_busy         = (state_q != StIdle);
  assign o_done         = done_q;
  assign o_err          = err_q;
  assign o_exec_cycles  = exec_q;
  assign o_qea_qbit_num = qbit_q;
  assign o_qea_ctx_en   = ctx_en_q;
  assign o_qea_ctx_wea  = ctx_en_q;
  assign o_qea_ctx_addr = ctx_addr_q;
  assign o_qea_ctx_data = ctx_data_q;
  assign o_res_valid    = (occ_q != 3'd0);
  assign o_res_data     = fifo_q[rd_ptr_q];
  assign o_res_last     = o_res_valid && last_word;

  // Read-latency shift register and count of reads still in flight
  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = issue;
    for (int i = 1; i < int'(RD_LAT); i++) pipe_d[i] = pipe_q[i-1];
    inflight = 3'd0;
    for (int i = 0; i < int'(RD_LAT); i++) inflight = inflight + 3'(pipe_q[i]);
  end

  // Next-state logic and RAM-port outputs
  always_comb begin
    state_d          = state_q;
    qbit_d           = qbit_q;
    ins_d            = ins_q;
    nwords_d         = nwords_q;
    ctx_cnt_d        = ctx_cnt_q;
    cnt_d            = cnt_q;
    res_cnt_d        = res_cnt_q;
    exec_d           = exec_q;
    err_d            = 1'b0;
    done_d           = 1'b0;
    ctx_en_d         = 1'b0;
    ctx_addr_d       = ctx_addr_q;
    ctx_data_d       = ctx_data_q;
    o_ctx_ready      = 1'b0;
    o_qea_start      = 1'b0;
    o_qea_state_ena  = 1'b0;
    o_qea_state_wea  = 1'b0;
    o_qea_state_addr = '0;
    o_qea_state_din  = '0;
    issue            = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_go) begin
          if (q_bad) begin
            err_d = 1'b1;
          end else begin
            qbit_d    = i_qbit_num;
            ins_d     = i_ins_num;
            nwords_d  = CW'(1) << (i_qbit_num - QMin);
            ctx_cnt_d = '0;
            cnt_d     = '0;
            state_d   = (i_ins_num == '0) ? StLdSt : StLdCtx;
          end
        end
      end
      StLdCtx: begin
        o_ctx_ready = 1'b1;
        if (i_ctx_valid) begin
          ctx_en_d   = 1'b1;
          ctx_addr_d = ctx_cnt_q[GATE_CONTEXT_ADDR_WIDTH-1:0];
          ctx_data_d = i_ctx_data;
          if (ctx_cnt_q == ins_q - NW'(1)) begin
            state_d = StLdSt;
            cnt_d   = '0;
          end else begin
            ctx_cnt_d = ctx_cnt_q + NW'(1);
          end
        end
      end
      StLdSt: begin
        o_qea_state_ena  = 1'b1;
        o_qea_state_wea  = 1'b1;
        o_qea_state_addr = cnt_q[STATE_ADDR_WIDTH-1:0];
        o_qea_state_din  = (cnt_q == '0) ? InitWord : '0;
        if (cnt_q == nwords_q - CW'(1)) begin
          state_d = StStart;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StStart: begin
        o_qea_start = 1'b1;
        exec_d      = '0;
        state_d     = StWait;
      end
      StWait: begin
        if (exec_q != 32'hFFFF_FFFF) exec_d = exec_q + 32'd1;
        if (i_qea_complete) begin
          state_d   = StRead;
          cnt_d     = '0;
          res_cnt_d = '0;
        end
      end
      StRead: begin
        // Reserve a FIFO slot for every outstanding read so backpressure never drops data
        issue            = (cnt_q < nwords_q) && ((inflight + occ_q) < 3'd4);
        o_qea_state_ena  = issue;
        o_qea_state_addr = cnt_q[STATE_ADDR_WIDTH-1:0];
        if (issue) cnt_d = cnt_q + CW'(1);
        if (pop) begin
          res_cnt_d = res_cnt_q + CW'(1);
          if (last_word) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      qbit_q     <= '0;
      ins_q      <= '0;
      nwords_q   <= '0;
      ctx_cnt_q  <= '0;
      cnt_q      <= '0;
      res_cnt_q  <= '0;
      exec_q     <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      ctx_en_q   <= 1'b0;
      ctx_addr_q <= '0;
      ctx_data_q <= '0;
      pipe_q     <= '0;
      occ_q      <= '0;
    end else begin
      state_q    <= state_d;
      qbit_q     <= qbit_d;
      ins_q      <= ins_d;
      nwords_q   <= nwords_d;
      ctx_cnt_q  <= ctx_cnt_d;
      cnt_q      <= cnt_d;
      res_cnt_q  <= res_cnt_d;
      exec_q     <= exec_d;
      err_q      <= err_d;
      done_q     <= done_d;
      ctx_en_q   <= ctx_en_d;
      ctx_addr_q <= ctx_addr_d;
      ctx_data_q <= ctx_data_d;
      pipe_q     <= pipe_d;
      occ_q      <= occ_d;
    end
  end

  // Four-entry result FIFO storage and pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= i_qea_state_dout;
        wr_ptr_q         <= wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
    end
  end

endmodule

// File: tb/tb_qea_host_sequencer.sv
// Directed bench for qea_host_sequencer with a behavioural QEA core model.
module tb_qea_host_sequencer;

  localparam logic [255:0] INIT_WORD = {64'h4000_0000_0000_0000, 192'h0};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_go = 1'b0;
  logic [5:0]   i_qbit_num = '0;
  logic [16:0]  i_ins_num = '0;
  logic         i_ctx_valid = 1'b0;
  logic         o_ctx_ready;
  logic [63:0]  i_ctx_data = '0;
  logic         o_qea_start;
  logic [5:0]   o_qea_qbit_num;
  logic         o_qea_ctx_en, o_qea_ctx_wea;
  logic [15:0]  o_qea_ctx_addr;
  logic [63:0]  o_qea_ctx_data;
  logic         o_qea_state_ena, o_qea_state_wea;
  logic [15:0]  o_qea_state_addr;
  logic [255:0] o_qea_state_din;
  logic         i_qea_complete = 1'b0;
  logic [255:0] i_qea_state_dout = '0;
  logic         o_res_valid;
  logic [255:0] o_res_data;
  logic         o_res_last;
  logic         i_res_ready = 1'b0;
  logic         o_busy, o_done, o_err;
  logic [31:0]  o_exec_cycles;

  always #5 clk = ~clk;

  qea_host_sequencer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_go             (i_go),
    .i_qbit_num       (i_qbit_num),
    .i_ins_num        (i_ins_num),
    .i_ctx_valid      (i_ctx_valid),
    .o_ctx_ready      (o_ctx_ready),
    .i_ctx_data       (i_ctx_data),
    .o_qea_start      (o_qea_start),
    .o_qea_qbit_num   (o_qea_qbit_num),
    .o_qea_ctx_en     (o_qea_ctx_en),
    .o_qea_ctx_wea    (o_qea_ctx_wea),
    .o_qea_ctx_addr   (o_qea_ctx_addr),
    .o_qea_ctx_data   (o_qea_ctx_data),
    .o_qea_state_ena  (o_qea_state_ena),
    .o_qea_state_wea  (o_qea_state_wea),
    .o_qea_state_addr (o_qea_state_addr),
    .o_qea_state_din  (o_qea_state_din),
    .i_qea_complete   (i_qea_complete),
    .i_qea_state_dout (i_qea_state_dout),
    .o_res_valid      (o_res_valid),
    .o_res_data       (o_res_data),
    .o_res_last       (o_res_last),
    .i_res_ready      (i_res_ready),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_err            (o_err),
    .o_exec_cycles    (o_exec_cycles)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Contents the model core "computed" at each state address
  function automatic logic [255:0] qword(input int unsigned a);
    logic [31:0] x;
    x = a;
    return {x, ~x, x ^ 32'h1234_5678, x + 32'd7, x ^ 32'hFFFF_0000, x * 32'd3,
            {x[15:0], x[31:16]}, 32'hC0DE_0000 + x};
  endfunction

  // QEA model: 1-cycle read latency, complete pulse 100 cycles after start
  int          cyc = 0;
  int          t_start = 0;
  bit          armed = 1'b0;
  bit          rd_pend = 1'b0;
  logic [15:0] rd_addr = '0;

  always @(posedge clk) begin
    if (rd_pend) i_qea_state_dout <= qword(32'(rd_addr));
    #1;
    cyc = cyc + 1;
    i_qea_complete = armed && (cyc == t_start + 100);
  end

  // Ready generator: constant level or 1010.. toggle
  bit toggle_rdy = 1'b0;
  bit rdy_level  = 1'b1;
  always @(posedge clk) begin
    #1;
    if (toggle_rdy) i_res_ready = ~i_res_ready;
    else            i_res_ready = rdy_level;
  end

  // Monitor, sampling on the falling edge
  int          n_start, start_wide, n_ctx, n_st_wr, st_bad, rd_idx, rd_bad, last_bad;
  int          n_done, n_err, n_busy, n_act, exp_words;
  bit          start_prev = 1'b0;
  logic [15:0] ctx_a [8];
  logic [63:0] ctx_d [8];
  logic        ctx_w [8];

  task automatic clear_mon();
    n_start = 0; start_wide = 0; n_ctx = 0; n_st_wr = 0; st_bad = 0; rd_idx = 0;
    rd_bad = 0; last_bad = 0; n_done = 0; n_err = 0; n_busy = 0; n_act = 0;
  endtask

  always @(negedge clk) begin
    logic [255:0] exp_din;
    rd_pend = o_qea_state_ena && !o_qea_state_wea;
    rd_addr = o_qea_state_addr;
    if (o_qea_start) begin
      n_start++;
      t_start = cyc;
      armed = 1'b1;
      if (start_prev) start_wide++;
    end
    start_prev = o_qea_start;
    if (o_qea_ctx_en) begin
      if (n_ctx < 8) begin
        ctx_a[n_ctx] = o_qea_ctx_addr;
        ctx_d[n_ctx] = o_qea_ctx_data;
        ctx_w[n_ctx] = o_qea_ctx_wea;
      end
      n_ctx++;
    end
    if (o_qea_state_ena && o_qea_state_wea) begin
      exp_din = (n_st_wr == 0) ? INIT_WORD : 256'h0;
      if (o_qea_state_addr != 16'(n_st_wr) || o_qea_state_din != exp_din) st_bad++;
      n_st_wr++;
    end
    if (o_res_valid && i_res_ready) begin
      if (o_res_data != qword(rd_idx)) rd_bad++;
      if (o_res_last != (rd_idx == exp_words - 1)) last_bad++;
      rd_idx++;
    end
    if (o_done) n_done++;
    if (o_err) n_err++;
    if (o_busy) n_busy++;
    if (o_qea_ctx_en || o_qea_state_ena || o_qea_start || o_ctx_ready || o_res_valid) n_act++;
  end

  task automatic go(input int q, input int n);
    @(posedge clk); #1;
    i_go = 1'b1;
    i_qbit_num = 6'(q);
    i_ins_num = 17'(n);
    @(posedge clk); #1;
    i_go = 1'b0;
  endtask

  task automatic send_ctx(input logic [63:0] d, input int gap);
    bit hs;
    hs = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
    i_ctx_valid = 1'b1;
    i_ctx_data = d;
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge clk);
      hs = o_ctx_ready;
    end
    check_eq("ctx_handshake", 256'(hs), 256'(1));
    @(posedge clk); #1;
    i_ctx_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string tag);
    int d0;
    d0 = n_done;
    for (int i = 0; i < limit && n_done == d0; i++) begin
      @(negedge clk); #1;
    end
    check_eq(tag, 256'(n_done - d0), 256'(1));
  endtask

  initial begin
    clear_mon();
    exp_words = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ctrl", 256'({o_busy, o_done, o_err, o_res_valid, o_qea_start, o_ctx_ready,
                               o_qea_ctx_en, o_qea_state_ena}), 256'(0));
    check_eq("rst_exec", 256'(o_exec_cycles), 256'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Out-of-range qubit counts; ctx valid is also held high while IDLE
    clear_mon();
    i_ctx_valid = 1'b1;
    go(1, 3);
    repeat (5) @(posedge clk);
    go(19, 3);
    repeat (5) @(posedge clk);
    #1 i_ctx_valid = 1'b0;
    check_eq("err_pulses", 256'(n_err), 256'(2));
    check_eq("err_busy", 256'(n_busy), 256'(0));
    check_eq("err_activity", 256'(n_act), 256'(0));

    // Q=4, N=3, context words with gaps
    clear_mon();
    exp_words = 4;
    go(4, 3);
    send_ctx(64'hAAAA_0000_1111_0001, 2);
    send_ctx(64'hBBBB_0000_2222_0002, 0);
    send_ctx(64'hCCCC_0000_3333_0003, 3);
    wait_done(2000, "a_done");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("a_ctx_count", 256'(n_ctx), 256'(3));
    check_eq("a_ctx_addr", 256'({ctx_a[0], ctx_a[1], ctx_a[2]}), 256'({16'd0, 16'd1, 16'd2}));
    check_eq("a_ctx_wea", 256'({ctx_w[0], ctx_w[1], ctx_w[2]}), 256'(3'b111));
    check_eq("a_ctx_d0", 256'(ctx_d[0]), 256'(64'hAAAA_0000_1111_0001));
    check_eq("a_ctx_d1", 256'(ctx_d[1]), 256'(64'hBBBB_0000_2222_0002));
    check_eq("a_ctx_d2", 256'(ctx_d[2]), 256'(64'hCCCC_0000_3333_0003));
    check_eq("a_st_writes", 256'(n_st_wr), 256'(4));
    check_eq("a_st_content", 256'(st_bad), 256'(0));
    check_eq("a_start_count", 256'(n_start), 256'(1));
    check_eq("a_start_width", 256'(start_wide), 256'(0));
    check_eq("a_exec", 256'(o_exec_cycles), 256'(100));
    check_eq("a_rd_words", 256'(rd_idx), 256'(4));
    check_eq("a_rd_data", 256'(rd_bad), 256'(0));
    check_eq("a_rd_last", 256'(last_bad), 256'(0));
    check_eq("a_qbit", 256'(o_qea_qbit_num), 256'(4));
    check_eq("a_done_pulses", 256'(n_done), 256'(1));
    check_eq("a_idle", 256'(o_busy), 256'(0));

    // Smallest legal run: Q=2, one state word
    clear_mon();
    exp_words = 1;
    go(2, 0);
    wait_done(2000, "q2_done");
    check_eq("q2_st_writes", 256'(n_st_wr), 256'(1));
    check_eq("q2_st_content", 256'(st_bad), 256'(0));
    check_eq("q2_rd_words", 256'(rd_idx), 256'(1));
    check_eq("q2_rd_last", 256'(last_bad + rd_bad), 256'(0));

    // Q=16, N=0, toggling ready, ignored i_go during WAIT
    clear_mon();
    exp_words = 16384;
    toggle_rdy = 1'b1;
    go(16, 0);
    @(negedge clk);
    check_eq("b_ldst_first", 256'({o_qea_state_ena, o_qea_state_wea, o_ctx_ready}), 256'(3'b110));
    for (int i = 0; i < 20000 && n_start == 0; i++) begin
      @(negedge clk); #1;
    end
    check_eq("b_started", 256'(n_start), 256'(1));
    repeat (10) @(posedge clk);
    go(4, 3);
    @(negedge clk);
    check_eq("b_busy_wait", 256'(o_busy), 256'(1));
    wait_done(40000, "b_done");
    toggle_rdy = 1'b0;
    check_eq("b_ctx_count", 256'(n_ctx), 256'(0));
    check_eq("b_start_count", 256'(n_start), 256'(1));
    check_eq("b_st_writes", 256'(n_st_wr), 256'(16384));
    check_eq("b_st_content", 256'(st_bad), 256'(0));
    check_eq("b_rd_words", 256'(rd_idx), 256'(16384));
    check_eq("b_rd_data", 256'(rd_bad), 256'(0));
    check_eq("b_rd_last", 256'(last_bad), 256'(0));
    check_eq("b_exec", 256'(o_exec_cycles), 256'(100));
    check_eq("b_qbit", 256'(o_qea_qbit_num), 256'(16));

    // Reset during READ, then a clean run
    clear_mon();
    exp_words = 64;
    go(8, 0);
    for (int i = 0; i < 2000 && rd_idx < 10; i++) begin
      @(negedge clk); #1;
    end
    check_eq("r_in_read", 256'(rd_idx >= 10), 256'(1));
    @(posedge clk); #1;
    rst_n = 1'b0;
    armed = 1'b0;
    @(negedge clk);
    check_eq("r_ctrl", 256'({o_busy, o_done, o_err, o_res_valid, o_res_last, o_qea_start,
                             o_ctx_ready, o_qea_ctx_en, o_qea_ctx_wea, o_qea_state_ena,
                             o_qea_state_wea}), 256'(0));
    check_eq("r_exec", 256'(o_exec_cycles), 256'(0));
    check_eq("r_qbit", 256'(o_qea_qbit_num), 256'(0));
    check_eq("r_res_data", o_res_data, 256'(0));
    check_eq("r_state_addr", 256'(o_qea_state_addr), 256'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    check_eq("r_no_done", 256'(n_done), 256'(0));
    clear_mon();
    exp_words = 4;
    go(4, 1);
    send_ctx(64'hDDDD_0000_4444_0004, 1);
    wait_done(2000, "r2_done");
    check_eq("r2_ctx", 256'({n_ctx[7:0], ctx_a[0], ctx_d[0]}),
             256'({8'd1, 16'd0, 64'hDDDD_0000_4444_0004}));
    check_eq("r2_st", 256'({n_st_wr[7:0], st_bad[7:0]}), 256'({8'd4, 8'd0}));
    check_eq("r2_rd", 256'({rd_idx[7:0], rd_bad[7:0], last_bad[7:0]}), 256'({8'd4, 8'd0, 8'd0}));
    check_eq("r2_exec", 256'(o_exec_cycles), 256'(100));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
